// File: rtl/msg_buf_pkg.sv
// Shared defaults for the message-buffer family.
// The addr_w helper keeps pointer widths consistent across sibling buffers.
package msg_buf_pkg;

    localparam int MSG_WIDTH_DEF = 8;
    localparam int DEPTH_DEF     = 8;

    function automatic int addr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);

endpackage

// File: rtl/msg_buf_mem.sv
// Simple dual-port storage array: synchronous write, synchronous registered read.
// No reset on the array or the read register; the owner masks stale data.
module msg_buf_mem
    import msg_buf_pkg::*;
#(
    parameter int WIDTH  = MSG_WIDTH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/msg_buffer_fifo.sv
// Circular message buffer with valid/ready on both sides and a registered output word.
// Holds DEPTH words in the array plus one in the output stage; sticky overflow, sync flush.
module msg_buffer_fifo
    import msg_buf_pkg::*;
#(
    parameter int  MSG_WIDTH = MSG_WIDTH_DEF,
    parameter int  DEPTH     = DEPTH_DEF,
    localparam int ADDR_W    = addr_w(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_valid_i,
    output logic                 wr_ready_o,
    input  logic [MSG_WIDTH-1:0] wr_data_i,
    output logic                 rd_valid_o,
    input  logic                 rd_ready_i,
    output logic [MSG_WIDTH-1:0] rd_data_o,
    output logic [ADDR_W:0]      count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 overflow_o
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      count_q, count_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 overflow_q, overflow_d;
    logic                 rd_zero_q, rd_zero_d;
    logic                 full;
    logic                 accept;
    logic                 load;
    logic [MSG_WIDTH-1:0] mem_rdata;

    assign full   = (count_q == DEPTH_CNT);
    assign accept = wr_valid_i && !full;
    assign load   = (!rd_valid_q || rd_ready_i) && (count_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_zero_d  = rd_zero_q;
        overflow_d = overflow_q | (wr_valid_i && full);
        count_d    = count_q + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, load};
        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_zero_d  = 1'b0;
        end else if (rd_ready_i) begin
            rd_valid_d = 1'b0;
        end
    end

    // Flush clears like reset but leaves the last output word visible.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            rd_zero_q  <= rd_zero_d;
        end
    end

    msg_buf_mem #(
        .WIDTH  (MSG_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (accept && !rst_i && !flush_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_data_i),
        .re_i    (load && !rst_i && !flush_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata)
    );

    assign wr_ready_o = !full;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_zero_q ? '0 : mem_rdata;
    assign count_o    = count_q;
    assign full_o     = full;
    assign empty_o    = (count_q == '0) && !rd_valid_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_msg_buffer_fifo.sv
// Bench for msg_buffer_fifo: directed scenarios plus random traffic against a queue model.
module tb_msg_buffer_fifo;

    localparam int D = 8;

    logic       clk = 1'b0;
    logic       rst, flush, wr_valid, rd_ready;
    logic [7:0] wr_data;
    logic       wr_ready, rd_valid, full, empty, overflow;
    logic [7:0] rd_data;
    logic [3:0] count;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    bit         m_rv;
    logic [7:0] m_rd;
    bit         m_ovf;

    always #5 clk = ~clk;

    msg_buffer_fifo #(.MSG_WIDTH(8), .DEPTH(D)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .wr_valid_i (wr_valid),
        .wr_ready_o (wr_ready),
        .wr_data_i  (wr_data),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .count_o    (count),
        .full_o     (full),
        .empty_o    (empty),
        .overflow_o (overflow)
    );

    // One clock edge: advance the queue model from the inputs, then settle.
    task automatic step();
        bit acc, ld;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_rv = 0; m_rd = 8'h00; m_ovf = 0;
        end else if (flush) begin
            mq.delete(); m_rv = 0; m_ovf = 0;
        end else begin
            acc = wr_valid && (mq.size() < D);
            if (wr_valid && mq.size() == D) m_ovf = 1;
            ld = (!m_rv || rd_ready) && (mq.size() > 0);
            if (ld) begin
                m_rd = mq.pop_front();
                m_rv = 1;
            end else if (m_rv && rd_ready) begin
                m_rv = 0;
            end
            if (acc) mq.push_back(wr_data);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; flush = 0; wr_valid = 0; rd_ready = 0; wr_data = 8'h00;
        step(); step();
        rst = 0;
        step();
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    endtask

    task automatic test_single();
        wr_valid = 1; wr_data = 8'hA5; rd_ready = 0;
        step();
        wr_valid = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass got %b exp 0", rd_valid); end
        step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_rd_data got %h exp a5", rd_data); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", empty); end
        rd_ready = 1;
        step();
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_consume got %b exp 0", rd_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %b exp 1", empty); end
        checks++; if (rd_data !== 8'hA5) begin errors++; $display("FAIL single_hold got %h exp a5", rd_data); end
    endtask

    task automatic test_fill_overflow();
        rd_ready = 0;
        for (int i = 1; i <= 9; i++) begin
            wr_valid = 1; wr_data = 8'(i);
            step();
        end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready got %b exp 0", wr_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_no_ovf got %b exp 0", overflow); end
        wr_data = 8'h0A;
        step();
        wr_valid = 0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b exp 1", overflow); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count_after_drop got %0d exp 8", count); end
        rd_ready = 1;
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errors++; $display("FAIL drain_word v=%b got %h exp %h", rd_valid, rd_data, 8'(i));
            end
            step();
        end
        rd_ready = 0;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL drain_end_valid got %b exp 0", rd_valid); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_end_empty got %b exp 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_stream();
        int exp_word = 0;
        rd_ready = 1;
        for (int i = 0; i < 34; i++) begin
            wr_valid = (i < 32);
            wr_data = 8'(i);
            step();
            checks++; if (count > 4'd1) begin errors++; $display("FAIL stream_count got %0d exp <=1", count); end
            if (i >= 1 && i <= 32) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'(exp_word)) begin
                    errors++; $display("FAIL stream_word v=%b got %h exp %h", rd_valid, rd_data, 8'(exp_word));
                end
                exp_word++;
            end
        end
        wr_valid = 0; rd_ready = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b exp 1", empty); end
    endtask

    task automatic test_simultaneous();
        rd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1; wr_data = 8'(8'h40 + i);
            step();
        end
        checks++; if (count !== 4'd3 || rd_valid !== 1'b1) begin
            errors++; $display("FAIL simul_setup count=%0d v=%b exp 3/1", count, rd_valid);
        end
        rd_ready = 1;
        for (int j = 0; j < 5; j++) begin
            wr_data = 8'(8'h44 + j);
            step();
            checks++; if (count !== 4'd3) begin errors++; $display("FAIL simul_count got %0d exp 3", count); end
            checks++; if (rd_data !== 8'(8'h41 + j)) begin
                errors++; $display("FAIL simul_order got %h exp %h", rd_data, 8'(8'h41 + j));
            end
        end
        wr_valid = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (rd_data !== 8'(8'h46 + k)) begin
                errors++; $display("FAIL simul_drain got %h exp %h", rd_data, 8'(8'h46 + k));
            end
        end
        step();
        rd_ready = 0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b exp 1", empty); end
    endtask

    task automatic test_flush();
        flush = 1; step(); flush = 0;
        rd_ready = 0;
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1; wr_data = 8'(8'h10 + i);
            step();
        end
        wr_valid = 0; rd_ready = 1;
        step(); step(); step();
        rd_ready = 0;
        checks++; if (count !== 4'd5 || rd_valid !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL flush_setup count=%0d v=%b ovf=%b exp 5/1/1", count, rd_valid, overflow);
        end
        flush = 1; wr_valid = 1; wr_data = 8'hEE;
        step();
        flush = 0; wr_valid = 0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_rd_valid got %b exp 0", rd_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b exp 0", overflow); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
        checks++; if (rd_data !== 8'h13) begin errors++; $display("FAIL flush_hold got %h exp 13", rd_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_write_dropped got %b exp 0", rd_valid); end
        wr_valid = 1; wr_data = 8'h3C;
        step();
        wr_valid = 0;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin
            errors++; $display("FAIL flush_readback v=%b got %h exp 3c", rd_valid, rd_data);
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_readback_count got %0d exp 0", count); end
        rd_ready = 1; step(); rd_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            rd_ready = ($urandom_range(0, 2) == 0) || (i > 300 && $urandom_range(0, 1) == 1);
            wr_data  = 8'($urandom);
            flush    = ($urandom_range(0, 59) == 0);
            step();
            checks++; if (rd_valid !== m_rv) begin errors++; $display("FAIL rand_rd_valid got %b exp %b", rd_valid, m_rv); end
            if (m_rv) begin
                checks++; if (rd_data !== m_rd) begin errors++; $display("FAIL rand_rd_data got %h exp %h", rd_data, m_rd); end
            end
            checks++; if (count !== 4'(mq.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, mq.size()); end
            checks++; if (full !== (mq.size() == D)) begin errors++; $display("FAIL rand_full got %b", full); end
            checks++; if (wr_ready !== (mq.size() != D)) begin errors++; $display("FAIL rand_wr_ready got %b", wr_ready); end
            checks++; if (empty !== (mq.size() == 0 && !m_rv)) begin errors++; $display("FAIL rand_empty got %b", empty); end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow got %b exp %b", overflow, m_ovf); end
        end
        flush = 0; wr_valid = 0; rd_ready = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_stream();
        test_simultaneous();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_buffer_fifo.md
Name: msg_buffer_fifo

Overview:
- Parametrised circular message buffer; successor to the single-pointer message RAM.
- Independent write and read pointers with valid/ready handshakes on both sides.
- Registered read stage, occupancy count, full/empty flags, sticky overflow flag and synchronous flush.
- Sits between a message producer (e.g. a UART/packet decoder) and a consumer that may stall.

Parameters:
- MSG_WIDTH, 8, width of one message word in bits.
- DEPTH, 8, number of storage words in the array; must be a power of 2 and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous clear of buffer contents.
- wr_valid  in  1  producer presents wr_data.
- wr_ready  out  1  buffer can accept; equals !full.
- wr_data  in  MSG_WIDTH  write word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ready  in  1  consumer takes the word.
- rd_data  out  MSG_WIDTH  registered read word.
- count  out  ADDR_W+1  words held in the array, 0..DEPTH; excludes the output register.
- full  out  1  count==DEPTH.
- empty  out  1  count==0 and !rd_valid.
- overflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data=0, overflow=0. Array contents are not reset. rst has priority over flush and all other inputs.
- Flush (flush=1, rst=0): same clears as reset except rd_data, which holds its value. The write attempted in the same cycle is dropped and overflow is not set.
- Write accept: wr_valid && wr_ready. Writes mem[wr_ptr] and increments wr_ptr; the pointer wraps from DEPTH-1 to 0 naturally through ADDR_W bits.
- Write while full (wr_valid && full): word dropped, pointers unchanged, overflow set to 1 at that edge. overflow stays 1 until rst or flush.
- Output stage load condition: (!rd_valid || rd_ready) && count>0.
  - On load: rd_data<=mem[rd_ptr], rd_valid<=1, rd_ptr increments with wrap, count decrements.
- Read consume (rd_valid && rd_ready) with no load possible: rd_valid<=0; rd_data holds its value.
- rd_ready while !rd_valid: ignored.
- Latency: a word accepted at edge N into an empty buffer appears with rd_valid=1 after edge N+1. There is no write-to-read bypass.
- Sustained throughput: 1 word/cycle when both sides are active and count>0.
- Simultaneous write accept and load in one cycle: count unchanged; both pointers advance.
- Same-address write and read in one cycle cannot occur; the load requires count>0, so rd_ptr!=wr_ptr unless full. When full, the write is blocked.
- count arithmetic: next = count + accept - load, computed in ADDR_W+1 bits. It never exceeds DEPTH and never underflows.
- full, empty and wr_ready are combinational from registered state only. There is no combinational path from any input to any output.
- Total capacity before wr_ready drops: DEPTH + 1 words (the array plus the output register) when the consumer is stalled.

Decomposition:
- Shared package msg_buf_pkg: default MSG_WIDTH and DEPTH constants, plus a clog2-based ADDR_W helper constant reused by sibling buffers.
- One sub-module, msg_buf_mem: a simple dual-port array with a synchronous write port and a synchronous read port, no reset.
- Pointer, count and handshake control stay in msg_buffer_fifo.

Test Plan:
- Reset then idle: after rst, count=0, empty=1, full=0, rd_valid=0, rd_data=0, overflow=0, wr_ready=1.
- Single word: write 0xA5 at edge N with rd_ready=0. Then rd_valid=1 and rd_data=0xA5 after edge N+1, count=0, empty=0. Assert rd_ready for one cycle: rd_valid=0, empty=1.
- Fill and overflow (DEPTH=8, rd_ready=0): write 0x01..0x09.
  - 0x01 moves to the output register; 0x02..0x09 fill the array (count=8, full=1, wr_ready=0).
  - A 10th write of 0x0A is dropped and overflow=1.
  - Drain reads 0x01..0x09 in order; 0x0A never appears.
- Wrap-around streaming: rd_ready=1 and continuous writes of 0x00..0x1F (32 words).
  - Reads are in order with no gaps after the first word, and count stays at most 1.
  - Covers four pointer wraps.
- Simultaneous events: with count=3 and rd_valid=1, assert wr_valid and rd_ready together for 5 cycles. count stays 3 and data order is preserved.
- Flush mid-operation: with count=5, rd_valid=1 and overflow=1, assert flush together with wr_valid. Next cycle: count=0, rd_valid=0, overflow=0, empty=1. The concurrent write is not stored, and a subsequent write of 0x3C reads back as 0x3C.
